// File: rtl/bk_pkg.sv
// -----------------------------------------------------------------------------
// bk_pkg
// Shared types and helpers for the backup-RAM sector transfer controller.
//   state_t      : transfer FSM states
//   SECTOR_BYTES : size of one SD sector moved per request
//   lba_of()     : builds the SD LBA from a slot number and a sector index
// -----------------------------------------------------------------------------
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_UP = 2'd2,
    WAIT_DN = 2'd3
  } state_t;

  localparam int SECTOR_BYTES = 512;

  // Each slot owns a contiguous run of 2^sect_log2 sectors in the image,
  // so the LBA is simply {slot, sector}. Computed 64 bits wide; callers
  // truncate to their own LBA width.
  function automatic logic [63:0] lba_of(input logic [63:0] slot_num,
                                         input logic [63:0] sect,
                                         input int          sect_log2);
    return (slot_num << sect_log2) | sect;
  endfunction

endpackage

// File: rtl/bk_sector_ctrl_if.sv
// -----------------------------------------------------------------------------
// bk_sector_ctrl_if
// SD sector handshake between the backup controller and hps_io.
//   sd_lba : sector address            (master -> slave)
//   sd_rd  : sector read request       (master -> slave)
//   sd_wr  : sector write request      (master -> slave)
//   sd_ack : sector acknowledge        (slave  -> master)
// The controller uses the master modport; hps_io (or a bench model) the slave.
// -----------------------------------------------------------------------------
interface bk_sector_ctrl_if #(
  parameter int LBA_W = 32
);

  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (
    output sd_lba,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );

endinterface

// File: rtl/bk_sector_ctrl.sv
// -----------------------------------------------------------------------------
// bk_sector_ctrl
// Backup-RAM transfer controller. Moves a cartridge NVRAM image between the
// on-chip NVRAM (port B) and the mounted SD save image, one 512-byte sector
// per sd_rd/sd_wr request, across 2^SLOT_W save slots of 2^SECT_LOG2 sectors.
//
// Parameters:
//   SECT_LOG2 : log2 of sectors per slot (0..8)
//   SLOT_W    : width of the slot select
//   LBA_W     : width of sd_lba (must match the interface instance)
//
// Ports:
//   clk_sys      : system clock, rising edge
//   RESET_n      : asynchronous active-low reset
//   bk_ena       : writable save image mounted; gates manual requests
//   bk_load      : OSD load request level (rising edge acts)
//   bk_save      : OSD save request level (rising edge acts)
//   mount_done   : one-cycle pulse at the end of a ROM download
//   img_size_nz  : mounted save image has non-zero size
//   slot         : slot select, sampled when a transfer starts
//   nvram_we     : core-side NVRAM write strobe (dirty tracking)
//   osd_status   : OSD open level (autosave only)
//   sd           : SD sector handshake (master modport)
//   nvram_sect   : current sector index, NVRAM port B high address bits
//   bk_state     : transfer in progress
//   bk_loading   : in-progress transfer is a load
//   dirty        : NVRAM modified since last load completion / save start
//   done         : one-cycle pulse when a transfer completes
//
// Build option:
//   BK_AUTOSAVE_EN : when defined, opening the OSD (osd_status rising) with
//                    dirty NVRAM starts a save to the selected slot.
// -----------------------------------------------------------------------------
module bk_sector_ctrl
  import bk_pkg::*;
#(
  parameter  int SECT_LOG2 = 6,
  parameter  int SLOT_W    = 2,
  parameter  int LBA_W     = 32,
  localparam int SECT_W    = (SECT_LOG2 < 1) ? 1 : SECT_LOG2
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              bk_ena,
  input  logic              bk_load,
  input  logic              bk_save,
  input  logic              mount_done,
  input  logic              img_size_nz,
  input  logic [SLOT_W-1:0] slot,
  input  logic              nvram_we,
  input  logic              osd_status,
  bk_sector_ctrl_if.master  sd,
  output logic [SECT_W-1:0] nvram_sect,
  output logic              bk_state,
  output logic              bk_loading,
  output logic              dirty,
  output logic              done
);

  localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'((1 << SECT_LOG2) - 1);

  state_t            state;
  state_t            state_next;

  logic              old_load;
  logic              old_save;
  logic              old_ack;
  logic [SLOT_W-1:0] slot_q;
  logic [SECT_W-1:0] sect_q;

  logic load_edge;
  logic save_edge;
  logic mount_go;
  logic auto_go;
  logic ack_rise;
  logic ack_fall;
  logic last_sect;
  logic start;
  logic start_load;
  logic finish;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // The edge registers already hold (x & bk_ena), so dropping bk_ena and
  // raising it again with the request still high counts as a new edge.
  assign load_edge = ~old_load & bk_load & bk_ena;
  assign save_edge = ~old_save & bk_save & bk_ena;
  assign mount_go  = mount_done & img_size_nz & bk_ena;
  assign ack_rise  = ~old_ack & sd.sd_ack;
  assign ack_fall  = old_ack & ~sd.sd_ack;
  assign last_sect = (sect_q == LAST_SECT);

`ifdef BK_AUTOSAVE_EN
  logic old_osd;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) old_osd <= 1'b0;
    else          old_osd <= osd_status;
  end

  assign auto_go = ~old_osd & osd_status & dirty & bk_ena & ~bk_state;
`else
  logic unused_osd;
  assign unused_osd = osd_status;
  assign auto_go    = 1'b0;
`endif

  // Any load source (mount or manual) beats a save; autosave is the
  // lowest-priority source and only ever produces a save.
  assign start      = (state == IDLE) & (mount_go | load_edge | save_edge | auto_go);
  assign start_load = mount_go | load_edge;
  assign finish     = (state == WAIT_DN) & ack_fall & last_sect;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is given its default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = REQ;
      REQ:                   state_next = WAIT_UP;
      WAIT_UP: if (ack_rise) state_next = WAIT_DN;
      WAIT_DN: begin
        if (ack_fall) state_next = last_sect ? IDLE : REQ;
      end
      default:               state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge-detect history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      old_load <= 1'b0;
      old_save <= 1'b0;
      old_ack  <= 1'b0;
    end else begin
      old_load <= bk_load & bk_ena;
      old_save <= bk_save & bk_ena;
      old_ack  <= sd.sd_ack;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer datapath and handshake outputs
  // ---------------------------------------------------------------------------
  // bk_loading doubles as the transfer direction for the whole transfer.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      slot_q     <= '0;
      sect_q     <= '0;
      bk_state   <= 1'b0;
      bk_loading <= 1'b0;
      done       <= 1'b0;
      sd.sd_lba  <= '0;
      sd.sd_rd   <= 1'b0;
      sd.sd_wr   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bk_loading <= start_load;
            slot_q     <= slot;
            sect_q     <= '0;
            bk_state   <= 1'b1;
          end
        end
        REQ: begin
          sd.sd_lba <= LBA_W'(lba_of(64'(slot_q), 64'(sect_q), SECT_LOG2));
          sd.sd_rd  <= bk_loading;
          sd.sd_wr  <= ~bk_loading;
        end
        WAIT_UP: begin
          if (ack_rise) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
          end
        end
        WAIT_DN: begin
          if (ack_fall) begin
            if (last_sect) begin
              bk_state   <= 1'b0;
              bk_loading <= 1'b0;
              done       <= 1'b1;
            end else begin
              sect_q <= sect_q + SECT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign nvram_sect = sect_q;

  // ---------------------------------------------------------------------------
  // Dirty tracking
  // ---------------------------------------------------------------------------
  // A save clears dirty as it starts (the image written is the snapshot being
  // taken); a load clears it only once the whole image has been read back.
  // A core write in the same cycle wins so no modification is ever lost.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dirty <= 1'b0;
    end else if (nvram_we) begin
      dirty <= 1'b1;
    end else if ((start & ~start_load) | (finish & bk_loading)) begin
      dirty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_sector_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bk_sector_ctrl
// Directed bench for bk_sector_ctrl with SECT_LOG2=2 (4 sectors per slot),
// SLOT_W=2, LBA_W=32. A table of transfer scenarios is applied in a loop and
// an in-bench hps_io model answers each sector request; reset-abort and
// autosave sequences are written out by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bk_sector_ctrl;

  localparam int SECT_LOG2 = 2;
  localparam int SLOT_W    = 2;
  localparam int LBA_W     = 32;
  localparam int NSECT     = 1 << SECT_LOG2;

  logic              clk_sys = 1'b0;
  logic              RESET_n;
  logic              bk_ena, bk_load, bk_save, mount_done, img_size_nz;
  logic [SLOT_W-1:0] slot;
  logic              nvram_we, osd_status;
  logic [1:0]        nvram_sect;
  logic              bk_state, bk_loading, dirty, done;

  bk_sector_ctrl_if #(.LBA_W(LBA_W)) sd ();

  bk_sector_ctrl #(
    .SECT_LOG2 (SECT_LOG2),
    .SLOT_W    (SLOT_W),
    .LBA_W     (LBA_W)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .bk_ena      (bk_ena),
    .bk_load     (bk_load),
    .bk_save     (bk_save),
    .mount_done  (mount_done),
    .img_size_nz (img_size_nz),
    .slot        (slot),
    .nvram_we    (nvram_we),
    .osd_status  (osd_status),
    .sd          (sd),
    .nvram_sect  (nvram_sect),
    .bk_state    (bk_state),
    .bk_loading  (bk_loading),
    .dirty       (dirty),
    .done        (done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Results captured by serve()
  int  n_req;
  int  req_lba [8];
  bit  req_rd  [8];
  bit  req_ld  [8];
  bit  done_seen, done_state, done_loading;
  bit  both_seen, sect_moved;

  // hps_io model: waits for a request, raises ack two cycles later, drops it
  // once the request is withdrawn. Optionally pulses nvram_we at a given
  // request, re-raises bk_save at request 1, or asserts reset in WAIT_DN of
  // a given request. Returns when done is seen or after a cycle budget.
  task automatic serve(input int we_req, input bit inject, input int abort_req,
                       output bit timed_out);
    int         phase = 0;
    int         dly   = 0;
    logic [1:0] cur_sect = '0;
    n_req = 0; done_seen = 0; done_state = 0; done_loading = 0;
    both_seen = 0; sect_moved = 0; timed_out = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_sys);
      nvram_we = 1'b0;
      bk_save  = 1'b0;
      if (sd.sd_rd && sd.sd_wr) both_seen = 1;
      if (done) begin
        done_seen    = 1;
        done_state   = bk_state;
        done_loading = bk_loading;
        timed_out    = 0;
        break;
      end
      case (phase)
        0: if (sd.sd_rd || sd.sd_wr) begin
          if (n_req < 8) begin
            req_lba[n_req] = int'(sd.sd_lba);
            req_rd[n_req]  = sd.sd_rd;
            req_ld[n_req]  = bk_loading;
          end
          cur_sect = nvram_sect;
          if (n_req == we_req)       nvram_we = 1'b1;
          if (inject && n_req == 1)  bk_save  = 1'b1;
          n_req++;
          dly   = 0;
          phase = 1;
        end
        1: begin
          if (nvram_sect != cur_sect) sect_moved = 1;
          dly++;
          if (dly == 2) begin
            sd.sd_ack = 1'b1;
            phase     = 2;
          end
        end
        default: begin
          if (nvram_sect != cur_sect) sect_moved = 1;
          if (!sd.sd_rd && !sd.sd_wr) begin
            if (n_req - 1 == abort_req) begin
              RESET_n   = 1'b0;
              timed_out = 0;
              break;
            end
            sd.sd_ack = 1'b0;
            phase     = 0;
          end
        end
      endcase
    end
  endtask

  typedef struct {
    string      name;
    bit         load, save, mount, img_nz, ena;
    logic [1:0] slot;
    bit         pre_we;
    int         we_req;
    bit         inject;
    bit         exp_start;
    bit         exp_rd;
    int         exp_base;
    bit         exp_dirty;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check_xfer(input string name, input bit exp_rd, input int base,
                            input bit timed_out);
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_nreq"}, n_req, NSECT);
    for (int k = 0; k < NSECT; k++) begin
      check($sformatf("%s_lba%0d", name, k), req_lba[k], base + k);
      check($sformatf("%s_rd%0d", name, k), req_rd[k], exp_rd);
      check($sformatf("%s_loading%0d", name, k), req_ld[k], exp_rd);
    end
    check({name, "_done"}, done_seen, 1);
    check({name, "_state_at_done"}, done_state, 0);
    check({name, "_loading_at_done"}, done_loading, 0);
    check({name, "_rd_wr_both"}, both_seen, 0);
    check({name, "_sect_stable"}, sect_moved, 0);
  endtask

  initial begin
    bit         to;
    bit         bad;
    vec_t       v;

    //           name           ld sv mt nz en slot pwe we  inj st rd base dirty
    vecs[0] = '{"save_s2",      0, 1, 0, 0, 1, 2'd2, 0, -1, 0, 1, 0,  8, 0};
    vecs[1] = '{"mount_load",   0, 0, 1, 1, 1, 2'd0, 0, -1, 0, 1, 1,  0, 0};
    vecs[2] = '{"save_we",      0, 1, 0, 0, 1, 2'd1, 0,  2, 0, 1, 0,  4, 1};
    vecs[3] = '{"load_s3",      1, 0, 0, 0, 1, 2'd3, 0, -1, 0, 1, 1, 12, 0};
    vecs[4] = '{"save_noena",   0, 1, 0, 0, 0, 2'd2, 0, -1, 0, 0, 0,  0, 0};
    vecs[5] = '{"mount_empty",  0, 0, 1, 0, 1, 2'd2, 0, -1, 0, 0, 0,  0, 0};
    vecs[6] = '{"load_and_save",1, 1, 0, 0, 1, 2'd0, 0, -1, 1, 1, 1,  0, 0};
    vecs[7] = '{"mount_vs_save",0, 1, 1, 1, 1, 2'd1, 0, -1, 0, 1, 1,  4, 0};
    vecs[8] = '{"save_cleans",  0, 1, 0, 0, 1, 2'd3, 1, -1, 0, 1, 0, 12, 0};

    RESET_n = 1'b0; bk_ena = 1'b0; bk_load = 1'b0; bk_save = 1'b0;
    mount_done = 1'b0; img_size_nz = 1'b0; slot = '0; nvram_we = 1'b0;
    osd_status = 1'b0; sd.sd_ack = 1'b0;

    repeat (3) @(negedge clk_sys);
    check("reset_outputs",
          {sd.sd_lba, sd.sd_rd, sd.sd_wr, nvram_sect, bk_state, bk_loading, dirty, done}, 0);
    RESET_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // ---------------- table-driven transfers ----------------
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.pre_we) begin
        @(negedge clk_sys); nvram_we = 1'b1;
        @(negedge clk_sys); nvram_we = 1'b0;
        check({v.name, "_pre_dirty"}, dirty, 1);
      end
      @(negedge clk_sys);
      bk_ena = v.ena; slot = v.slot; bk_load = v.load; bk_save = v.save;
      mount_done = v.mount; img_size_nz = v.img_nz;
      @(negedge clk_sys);
      bk_load = 1'b0; bk_save = 1'b0; mount_done = 1'b0;
      slot = v.slot ^ 2'b11;   // slot must have been latched at start
      if (v.exp_start) begin
        check({v.name, "_state_start"}, bk_state, 1);
        check({v.name, "_loading_start"}, bk_loading, v.exp_rd);
        serve(v.we_req, v.inject, -1, to);
        check_xfer(v.name, v.exp_rd, v.exp_base, to);
        repeat (4) @(negedge clk_sys);
        check({v.name, "_idle_after"}, {bk_state, sd.sd_rd, sd.sd_wr}, 0);
      end else begin
        bad = 0;
        repeat (6) begin
          @(negedge clk_sys);
          if (sd.sd_rd || sd.sd_wr || bk_state) bad = 1;
        end
        check({v.name, "_no_start"}, bad, 0);
      end
      check({v.name, "_dirty"}, dirty, v.exp_dirty);
      bk_ena = 1'b1;
    end

    // ---------------- reset during WAIT_DN of sector 1 ----------------
    @(negedge clk_sys);
    slot = 2'd2; bk_save = 1'b1;
    @(negedge clk_sys);
    bk_save = 1'b0;
    serve(-1, 0, 1, to);
    check("abort_reached", to, 0);
    check("abort_nreq", n_req, 2);
    #1;
    check("abort_outputs",
          {sd.sd_lba, sd.sd_rd, sd.sd_wr, nvram_sect, bk_state, bk_loading, dirty, done}, 0);
    sd.sd_ack = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (done) bad = 1;
    end
    RESET_n = 1'b1;
    repeat (3) begin
      @(negedge clk_sys);
      if (done || bk_state) bad = 1;
    end
    check("abort_no_done", bad, 0);
    @(negedge clk_sys);
    bk_save = 1'b1;
    @(negedge clk_sys);
    bk_save = 1'b0;
    serve(-1, 0, -1, to);
    check_xfer("restart", 0, 8, to);

    // ---------------- OSD-open autosave ----------------
    @(negedge clk_sys); nvram_we = 1'b1;
    @(negedge clk_sys); nvram_we = 1'b0;
    check("auto_pre_dirty", dirty, 1);
    slot = 2'd1;
    osd_status = 1'b1;
`ifdef BK_AUTOSAVE_EN
    @(negedge clk_sys);
    check("auto_state_start", bk_state, 1);
    serve(-1, 0, -1, to);
    check_xfer("autosave", 0, 4, to);
    check("auto_dirty", dirty, 0);
`else
    bad = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (sd.sd_rd || sd.sd_wr || bk_state) bad = 1;
    end
    check("no_autosave", bad, 0);
    check("no_autosave_dirty", dirty, 1);
`endif
    osd_status = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
